// File: rtl/dac_pkg.sv
// Shared DAC definitions: code width and the midscale reset code.
package dac_pkg;

  localparam int unsigned DAC_DATA_W = 10;
  localparam logic [DAC_DATA_W-1:0] DAC_MIDSCALE = 10'h200;

  typedef logic [DAC_DATA_W-1:0] dac_code_t;

endpackage : dac_pkg

// File: rtl/dac_sample_pacer_if.sv
// Upstream valid/ready sample stream feeding the pacer.
interface dac_sample_pacer_if #(
  parameter int unsigned DATA_W = 10
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface : dac_sample_pacer_if

// File: rtl/sample_fifo.sv
// Synchronous FIFO with explicit level; the caller gates push/pop against full/empty.
module sample_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;

  // Storage is not reset; reset only clears the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule : sample_fifo

// File: rtl/dac_sample_pacer.sv
// Sample-rate pacer: buffers DAC codes and releases one per programmable period.
module dac_sample_pacer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W = DAC_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                   CLK,
  input  logic                   reset,
  dac_sample_pacer_if.slave      s,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       div,
  input  logic                   clr_underflow,
  output logic [DATA_W-1:0]      D,
  output logic                   strobe,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DIV_W-1:0]  cnt;
  logic [DATA_W-1:0] head;
  logic              tick;
  logic              push;
  logic              pop;

  // s_ready depends on registered level only, so it never loops back through s_valid.
  assign s.s_ready = (level != LVL_W'(DEPTH));

  always_comb begin
    tick = enable && (cnt >= div);
    push = s.s_valid && s.s_ready;
    pop  = tick && (level != '0);
  end

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (s.s_data),
    .head  (head),
    .level (level)
  );

  // Period counter; >= compare makes a shrunk div tick on the next edge.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + DIV_W'(1);
  end

  // Output code, strobe and sticky underflow; a new underflow wins over the clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      D         <= MIDSCALE;
      strobe    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      strobe <= pop;
      if (pop) D <= head;
      if (tick && (level == '0)) underflow <= 1'b1;
      else if (clr_underflow)    underflow <= 1'b0;
    end
  end

endmodule : dac_sample_pacer

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer with a cycle model and a sample scoreboard.
module tb_dac_sample_pacer;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DIV_W  = 16;

  logic              CLK = 1'b0;
  logic              reset;
  logic              enable;
  logic [DIV_W-1:0]  div;
  logic              clr_underflow;
  logic [DATA_W-1:0] D;
  logic              strobe;
  logic              underflow;
  logic [3:0]        level;

  dac_sample_pacer_if #(.DATA_W(DATA_W)) bus ();

  dac_sample_pacer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIV_W  (DIV_W)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .s             (bus),
    .enable        (enable),
    .div           (div),
    .clr_underflow (clr_underflow),
    .D             (D),
    .strobe        (strobe),
    .underflow     (underflow),
    .level         (level)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] sb[$];
  int                m_cnt;
  logic [DATA_W-1:0] m_d;
  logic              m_strobe;
  logic              m_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt    = 0;
    m_d      = 10'h200;
    m_strobe = 1'b0;
    m_uf     = 1'b0;
  endtask

  // One clock edge: predict from pre-edge state, then compare all outputs #1 after the edge.
  task automatic step();
    logic acc, tck, popm;
    logic [DATA_W-1:0] wd;
    acc  = bus.s_valid && (sb.size() != DEPTH);
    wd   = bus.s_data;
    tck  = enable && (m_cnt >= int'(div));
    popm = tck && (sb.size() > 0);
    @(posedge CLK);
    if (popm) m_d = sb.pop_front();
    if (acc) sb.push_back(wd);
    m_strobe = popm;
    if (tck && !popm)       m_uf = 1'b1;
    else if (clr_underflow) m_uf = 1'b0;
    if (!enable || tck) m_cnt = 0;
    else                m_cnt = m_cnt + 1;
    #1;
    chk("D", 32'(D), 32'(m_d));
    chk("strobe", 32'(strobe), 32'(m_strobe));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("level", 32'(level), 32'(sb.size()));
    chk("s_ready", 32'(bus.s_ready), 32'(sb.size() != DEPTH));
  endtask

  task automatic push_one(input logic [DATA_W-1:0] v);
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    step();
    bus.s_valid = 1'b0;
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    chk("rst_D", 32'(D), 32'h200);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  int n;
  int nstb;
  int last;
  logic [DATA_W-1:0] first_v;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    div = '0;
    clr_underflow = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("init_D", 32'(D), 32'h200);
    chk("init_level", 32'(level), 32'd0);
    reset = 1'b0;

    // 1: reset mid-stream with 5 entries queued
    for (int i = 0; i < 6; i++) push_one(DATA_W'(10'h050 + i));
    div = 16'd1;
    enable = 1'b1;
    step();
    step();
    chk("t1_level_before", 32'(level), 32'd5);
    pulse_reset();
    enable = 1'b0;
    step();

    // 2: pacing div=3, three codes, one every 4 cycles
    div = 16'd3;
    enable = 1'b1;
    push_one(10'h000);
    push_one(10'h3FF);
    push_one(10'h155);
    nstb = 0;
    last = 0;
    for (int c = 4; c <= 12; c++) begin
      step();
      if (strobe) begin
        nstb++;
        chk("t2_period", 32'(c - last), 32'(last == 0 ? 4 : 4));
        last = c;
      end
    end
    chk("t2_strobes", 32'(nstb), 32'd3);
    chk("t2_last_D", 32'(D), 32'h155);
    chk("t2_no_uf", 32'(underflow), 32'd0);
    enable = 1'b0;
    step();

    // 3: full with s_valid held high, 9th held until a tick frees a slot
    pulse_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.s_data = (sb.size() < DEPTH) ? DATA_W'(10'h100 + sb.size()) : 10'h2EE;
      step();
    end
    chk("t3_full_level", 32'(level), 32'd8);
    chk("t3_full_ready", 32'(bus.s_ready), 32'd0);
    bus.s_data = 10'h2EE;
    div = 16'd0;
    enable = 1'b1;
    step();
    chk("t3_freed_ready", 32'(bus.s_ready), 32'd1);
    chk("t3_first_D", 32'(D), 32'h100);
    enable = 1'b0;
    step();
    bus.s_valid = 1'b0;
    chk("t3_refilled", 32'(level), 32'd8);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("t3_last_D", 32'(D), 32'h2EE);
    enable = 1'b0;
    step();

    // 4: underflow, clear coinciding with a new empty tick
    pulse_reset();
    push_one(10'h2A5);
    div = 16'd1;
    enable = 1'b1;
    step();
    step();
    chk("t4_first_tick_D", 32'(D), 32'h2A5);
    chk("t4_first_tick_strobe", 32'(strobe), 32'd1);
    n = 0;
    while (!underflow && n < 6) begin
      step();
      n++;
    end
    chk("t4_uf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      clr_underflow = (m_cnt >= int'(div));
      step();
      if (clr_underflow) break;
    end
    chk("t4_clr_same_tick", 32'(clr_underflow), 32'd1);
    chk("t4_uf_wins", 32'(underflow), 32'd1);
    chk("t4_D_hold", 32'(D), 32'h2A5);
    step();
    clr_underflow = 1'b0;
    chk("t4_uf_cleared", 32'(underflow), 32'd0);
    enable = 1'b0;
    step();

    // 5: simultaneous push and pop at level 4 across pointer wrap
    pulse_reset();
    for (int i = 0; i < 4; i++) push_one(DATA_W'($urandom));
    div = 16'd0;
    enable = 1'b1;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus.s_data = DATA_W'($urandom);
      step();
      chk("t5_level4", 32'(level), 32'd4);
    end
    bus.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_drained", 32'(level), 32'd0);
    enable = 1'b0;
    step();

    // 6: enable drop at cnt=5, next tick exactly 10 cycles after re-enable
    pulse_reset();
    first_v = 10'h0C3;
    push_one(first_v);
    push_one(10'h33C);
    div = 16'd9;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_intact", 32'(level), 32'd2);
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (strobe) break;
    end
    chk("t6_reenable_latency", 32'(n), 32'd10);
    chk("t6_D", 32'(D), 32'(first_v));
    chk("t6_level", 32'(level), 32'd1);
    enable = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_dac_sample_pacer
